table_mealy_fsm: RTL and testbench

Programmable Mealy automaton that replaces the hand-minimised, single-use controllers in this codebase. Instead of fixed next-state and output equations, a register-based transition table holds a {next_state, outputs} entry for every (state, input) pair. The table is loaded through a configuration port while the machine is stopped, then the machine steps once per clock while `run` is high. It sits between the input conditioners and the datapath control lines, exactly where a generated controller would go.

---
 rtl/table_mealy_fsm.sv | 55 +++++
 tb/tb_table_mealy_fsm.sv | 127 ++++++++++++
 2 files changed

// File: rtl/table_mealy_fsm.sv
// table_mealy_fsm: register-table programmable Mealy automaton with config port and saturating transition counter
module table_mealy_fsm #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 5,
  parameter int ST_W  = 4,
  parameter int N_ST  = 9,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  run,
  input  logic [IN_W-1:0]       x,
  output logic [OUT_W-1:0]      t,
  output logic [ST_W-1:0]       state,
  input  logic                  cfg_we,
  input  logic [ST_W+IN_W-1:0]  cfg_addr,
  input  logic [ST_W+OUT_W-1:0] cfg_data,
  output logic                  cfg_err,
  output logic                  bad_st,
  output logic [CNT_W-1:0]      trans_cnt
);
  localparam int A_W = ST_W + IN_W;
  localparam int D_W = ST_W + OUT_W;
  localparam int N_E = N_ST * (2 ** IN_W);
  localparam logic [ST_W:0] n_st_c = N_ST[ST_W:0];
  logic [D_W-1:0] tbl [N_E];
  logic [D_W-1:0] entry;
  logic [ST_W-1:0] nxt, nxt_st;
  logic bad, wr_ok;
  always_comb begin
    entry  = tbl[{state, x}];
    nxt    = entry[D_W-1:OUT_W];
    bad    = !({1'b0, nxt} < n_st_c);
    nxt_st = bad ? '0 : nxt;
    t      = run ? entry[OUT_W-1:0] : '0;
    wr_ok  = cfg_we && !run && ({1'b0, cfg_addr[A_W-1:IN_W]} < n_st_c);
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= '0;
      bad_st    <= 1'b0;
      cfg_err   <= 1'b0;
      trans_cnt <= '0;
      for (int i = 0; i < N_E; i++) tbl[i] <= '0;
    end else begin
      cfg_err <= cfg_we && !wr_ok;
      if (wr_ok) tbl[cfg_addr] <= cfg_data;
      if (run) begin
        state <= nxt_st;
        if (bad) bad_st <= 1'b1;
        if (nxt_st != state && trans_cnt != '1) trans_cnt <= trans_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_table_mealy_fsm.sv
// tb_table_mealy_fsm: scoreboard bench for table_mealy_fsm (default instance plus a CNT_W=4 instance)
module tb_table_mealy_fsm;
  logic clk = 0;
  logic res = 0, run = 0, cfg_we = 0;
  logic [1:0] x = 0;
  logic [5:0] cfg_addr = 0;
  logic [8:0] cfg_data = 0;
  logic [4:0] t, t4;
  logic [3:0] state, state4;
  logic cfg_err, cfg_err4, bad_st, bad_st4;
  logic [15:0] trans_cnt;
  logic [3:0] cnt4;
  int total = 0, nbad = 0;
  typedef struct {logic [3:0] st; logic bd; int cnt; logic err;} exp_t;
  exp_t sb[$];
  logic [8:0] m_tbl [36];
  logic [3:0] m_st;
  logic m_bad;
  int m_cnt;
  always #5 clk = ~clk;
  table_mealy_fsm dut (.clk(clk), .res(res), .run(run), .x(x), .t(t), .state(state), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err), .bad_st(bad_st), .trans_cnt(trans_cnt));
  table_mealy_fsm #(.CNT_W(4)) dut4 (.clk(clk), .res(res), .run(run), .x(x), .t(t4), .state(state4),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err4), .bad_st(bad_st4),
    .trans_cnt(cnt4));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic ru, input logic [1:0] xx, input logic we,
                     input logic [5:0] a, input logic [8:0] d);
    logic [8:0] e;
    logic [3:0] n;
    exp_t ex, got;
    @(negedge clk);
    res = r; run = ru; x = xx; cfg_we = we; cfg_addr = a; cfg_data = d;
    #1;
    e = m_tbl[{m_st, xx}];
    check("t", t, ru ? e[4:0] : 5'd0);
    if (r) begin
      m_st = 0; m_bad = 0; m_cnt = 0;
      for (int i = 0; i < 36; i++) m_tbl[i] = 0;
      ex.err = 0;
    end else begin
      ex.err = we && (ru || a[5:2] >= 4'd9);
      if (we && !ru && a[5:2] < 4'd9) m_tbl[a] = d;
      if (ru) begin
        n = e[8:5];
        if (n >= 4'd9) begin n = 0; m_bad = 1; end
        if (n != m_st) m_cnt++;
        m_st = n;
      end
    end
    ex.st = m_st; ex.bd = m_bad; ex.cnt = m_cnt;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) check("sb_empty", 1, 0);
    else begin
      got = sb.pop_front();
      check("state", state, got.st);
      check("bad_st", bad_st, got.bd);
      check("cfg_err", cfg_err, got.err);
      check("trans_cnt", trans_cnt, got.cnt > 65535 ? 65535 : got.cnt);
      check("trans_cnt4", cnt4, got.cnt > 15 ? 15 : got.cnt);
    end
  endtask
  task automatic wr(input logic [5:0] a, input logic [8:0] d);
    cyc(0, 0, 2'b00, 1, a, d);
  endtask
  task automatic st(input logic [1:0] xx);
    cyc(0, 1, xx, 0, 6'd0, 9'd0);
  endtask
  initial begin
    m_st = 0; m_bad = 0; m_cnt = 0;
    for (int i = 0; i < 36; i++) m_tbl[i] = 0;
    cyc(1, 0, 2'b00, 0, 6'd0, 9'd0);
    repeat (3) st(2'b11);
    check("idle_state", state, 0);
    wr({4'd0, 2'b01}, {4'd5, 5'b00010});
    st(2'b01);
    check("prog_state", state, 5);
    check("prog_cnt", trans_cnt, 1);
    cyc(0, 1, 2'b00, 1, {4'd0, 2'b01}, {4'd7, 5'b11111});
    check("rej_run_err", cfg_err, 1);
    cyc(0, 0, 2'b00, 0, 6'd0, 9'd0);
    check("rej_run_pulse", cfg_err, 0);
    st(2'b01);
    wr({4'd9, 2'b00}, {4'd1, 5'b10101});
    check("rej_addr_err", cfg_err, 1);
    wr({4'd15, 2'b11}, {4'd2, 5'b01010});
    cyc(0, 0, 2'b00, 0, 6'd0, 9'd0);
    check("rej_addr_pulse", cfg_err, 0);
    wr({4'd3, 2'b00}, {4'd12, 5'b10101});
    wr({4'd5, 2'b10}, {4'd3, 5'b00100});
    st(2'b10);
    check("to_s3", state, 3);
    st(2'b00);
    check("illegal_state", state, 0);
    check("illegal_bad", bad_st, 1);
    repeat (3) st(2'b11);
    check("bad_sticky", bad_st, 1);
    wr({4'd0, 2'b10}, {4'd1, 5'b00001});
    wr({4'd1, 2'b10}, {4'd0, 5'b00011});
    wr({4'd1, 2'b11}, {4'd1, 5'b11000});
    repeat (21) st(2'b10);
    check("sat_cnt4", cnt4, 15);
    repeat (2) st(2'b11);
    check("selfloop_cnt4", cnt4, 15);
    cyc(1, 0, 2'b00, 0, 6'd0, 9'd0);
    check("bad_cleared", bad_st, 0);
    wr({4'd0, 2'b01}, {4'd5, 5'b00110});
    wr({4'd5, 2'b00}, {4'd5, 5'b01111});
    st(2'b01);
    st(2'b00);
    cyc(1, 1, 2'b00, 1, {4'd5, 2'b00}, {4'd2, 5'b11111});
    check("midrst_state", state, 0);
    check("midrst_err", cfg_err, 0);
    for (int i = 0; i < 4; i++) st(i[1:0]);
    for (int i = 0; i < 4; i++) cyc(0, 1, i[1:0], 0, 6'd0, 9'd0);
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
endmodule
